// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state type,
// legal range of the MAX_LEN parameter and the length-field width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam int MAX_LEN_MIN = 2;
  localparam int MAX_LEN_MAX = 32;

  // Width of a length field able to hold the values 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Shift window, fill counter and masked pattern compare for the detector.
// Only MAX_LEN-1 history bits are kept; the full MAX_LEN-bit window after a
// shift is formed combinationally from that history and the incoming bit,
// which is the only window the compare ever looks at.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               fill_clr_i,
  input  logic               seq_in_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic [LEN_W-1:0]   fill_o,
  output logic               hit_o
);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] win_next_s;
  logic [MAX_LEN-1:0] mask_s;

  // Updated window and compare of its low len_i bits against the pattern.
  always_comb begin
    win_next_s = {hist_q, seq_in_i};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (len_i > LEN_W'(i));
    end
    hit_o = (((win_next_s ^ pattern_i) & mask_s) == {MAX_LEN{1'b0}});
  end

  // Next window and fill: clear has priority, then shift with saturation.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = {(MAX_LEN-1){1'b0}};
      fill_d = {LEN_W{1'b0}};
    end else if (shift_i) begin
      hist_d = win_next_s[MAX_LEN-2:0];
      if (fill_clr_i) begin
        fill_d = {LEN_W{1'b0}};
      end else if (fill_q == len_i) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // Window and fill registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= {(MAX_LEN-1){1'b0}};
      fill_q <= {LEN_W{1'b0}};
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Configurable serial bit-pattern detector (overlapping or non-overlapping).
// Optional feature macro: SEQ_DET_COUNT_EN adds the saturating match counter
// and the match_cnt_o port.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               seq_valid,
  input  logic               seq_in,
  output logic               det_o,
  output logic               armed_o,
  output logic               cfg_err_o
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt_o
`endif
);

  localparam logic [LEN_W-1:0] LenOne = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               err_q, err_d;
  logic               det_q, det_d;
  logic               armed_q, armed_d;

  logic [LEN_W-1:0]   fill_s;
  logic               hit_s;
  logic               legal_s;
  logic               accept_s;
  logic               complete_s;
  logic               match_s;
  logic               win_clear_s;
  logic               win_shift_s;
  logic               fill_clr_s;

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (win_clear_s),
    .shift_i    (win_shift_s),
    .fill_clr_i (fill_clr_s),
    .seq_in_i   (seq_in),
    .pattern_i  (pattern_q),
    .len_i      (len_q),
    .fill_o     (fill_s),
    .hit_o      (hit_s)
  );

  // Acceptance and match qualification; a load in the same cycle wins over data.
  always_comb begin
    legal_s    = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
    accept_s   = seq_valid && !cfg_load && ((state_q == FILL) || (state_q == ARMED));
    complete_s = accept_s && ((state_q == ARMED) || (fill_s == (len_q - LenOne)));
    match_s    = complete_s && hit_s;
  end

  // FSM next state, configuration capture and window control.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    err_d       = err_q;
    det_d       = 1'b0;
    win_clear_s = 1'b0;
    win_shift_s = 1'b0;
    fill_clr_s  = 1'b0;
    if (cfg_load) begin
      win_clear_s = 1'b1;
      if (legal_s) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        err_d     = 1'b0;
        state_d   = FILL;
      end else begin
        err_d   = 1'b1;
        state_d = UNCFG;
      end
    end else if (accept_s) begin
      win_shift_s = 1'b1;
      case (state_q)
        FILL: begin
          if (complete_s) begin
            state_d = ARMED;
          end else begin
            state_d = FILL;
          end
        end
        ARMED:   state_d = ARMED;
        default: state_d = UNCFG;
      endcase
      if (match_s) begin
        det_d = 1'b1;
        if (!overlap_q) begin
          // Non-overlapping: the matched bits cannot start the next match.
          fill_clr_s = 1'b1;
          if (len_q == LenOne) begin
            state_d = ARMED;
          end else begin
            state_d = FILL;
          end
        end else begin
          fill_clr_s = 1'b0;
        end
      end else begin
        det_d = 1'b0;
      end
    end else begin
      case (state_q)
        UNCFG, FILL, ARMED: state_d = state_q;
        default:            state_d = UNCFG;
      endcase
    end
    armed_d = (state_d == ARMED);
  end

  // State, configuration and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= UNCFG;
      pattern_q <= {MAX_LEN{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      overlap_q <= 1'b0;
      err_q     <= 1'b0;
      det_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
      det_q     <= det_d;
      armed_q   <= armed_d;
    end
  end

  assign det_o     = det_q;
  assign armed_o   = armed_q;
  assign cfg_err_o = err_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter, cleared by any configuration load.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus a
// randomized run against a history-based reference model. Two instances share
// the stimulus; the second uses a 2-bit counter to exercise saturation.
module tb_seq_pattern_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       seq_valid = 1'b0;
  logic       seq_in = 1'b0;

  logic det_a, armed_a, err_a;
  logic det_b, armed_b, err_b;
`ifdef SEQ_DET_COUNT_EN
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_cfg, m_err, m_armed, m_ov, m_det;
  logic [7:0]  m_pat;
  int          m_len, m_hcnt, m_cnt_a, m_cnt_b;
  logic [63:0] m_hist;

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq_valid(seq_valid), .seq_in(seq_in),
    .det_o(det_a), .armed_o(armed_a), .cfg_err_o(err_a)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt_o(cnt_a)
`endif
  );

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq_valid(seq_valid), .seq_in(seq_in),
    .det_o(det_b), .armed_o(armed_b), .cfg_err_o(err_b)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt_o(cnt_b)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_cfg = 1'b0; m_err = 1'b0; m_armed = 1'b0; m_ov = 1'b0; m_det = 1'b0;
    m_pat = 8'd0; m_len = 0; m_hcnt = 0; m_hist = 64'd0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // One clock of stimulus; the model is advanced to what the outputs must show after the edge.
  task automatic drive(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                       input bit ov, input bit v, input bit b);
    logic [63:0] mask;
    cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    seq_valid = v; seq_in = b;
    @(posedge clock);
    m_det = 1'b0;
    if (ld) begin
      if (len >= 4'd1 && len <= 4'd8) begin
        m_cfg = 1'b1; m_err = 1'b0; m_pat = pat; m_len = int'(len); m_ov = ov;
      end else begin
        m_cfg = 1'b0; m_err = 1'b1;
      end
      m_hist = 64'd0; m_hcnt = 0; m_armed = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (v && m_cfg) begin
      m_hist = {m_hist[62:0], b};
      if (m_hcnt < 64) m_hcnt++;
      if (m_hcnt >= m_len) begin
        m_armed = 1'b1;
        mask = (64'd1 << m_len) - 64'd1;
        if (((m_hist ^ {56'd0, m_pat}) & mask) == 64'd0) begin
          m_det = 1'b1;
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
          if (!m_ov) begin
            m_hcnt = 0;
            if (m_len != 1) m_armed = 1'b0;
          end
        end
      end
    end
    #1;
    cfg_load = 1'b0; seq_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({det_a, armed_a, err_a, det_b, armed_b, err_b} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {det_a, armed_a, err_a, det_b, armed_b, err_b});
    end
`ifdef SEQ_DET_COUNT_EN
    n_checks++;
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", cnt_a, cnt_b);
    end
`endif
  endtask

  task automatic test_stream_1011(input bit ov);
    logic [6:0] stream;
    bit exp;
    stream = 7'b1011011;
    drive(1'b1, 8'b0000_1011, 4'd4, ov, 1'b0, 1'b0);
    n_checks++;
    if (armed_a !== 1'b0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load_1011 ov=%0d: armed/err %b%b required 00", ov, armed_a, err_a);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, stream[6-i]);
      exp = (i == 3) || (ov && i == 6);
      n_checks++;
      if (det_a !== exp || det_b !== exp) begin
        n_fail++;
        $display("FAIL det_1011 ov=%0d bit%0d: got %b/%b required %b", ov, i+1, det_a, det_b, exp);
      end
    end
    n_checks++;
    if (armed_a !== ov) begin
      n_fail++;
      $display("FAIL armed_1011 ov=%0d: got %b required %b", ov, armed_a, ov);
    end
`ifdef SEQ_DET_COUNT_EN
    n_checks++;
    if (cnt_a !== (ov ? 16'd2 : 16'd1)) begin
      n_fail++;
      $display("FAIL count_1011 ov=%0d: got %0d required %0d", ov, cnt_a, ov ? 2 : 1);
    end
`endif
  endtask

  task automatic test_illegal_cfg();
    logic [3:0] bad [2];
    logic [3:0] stream;
    bad[0] = 4'd0; bad[1] = 4'd9; stream = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'b0000_1011, bad[k], 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, stream[3 - (i % 4)]);
        n_checks++;
        if (err_a !== 1'b1 || armed_a !== 1'b0 || det_a !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_len%0d bit%0d: err/armed/det %b%b%b required 100",
                   bad[k], i, err_a, armed_a, det_a);
        end
      end
    end
    drive(1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_then_legal: err got %b required 0", err_a);
    end
  endtask

  task automatic test_stall();
    bit exp;
    drive(1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < 3)      drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, (i != 1));
      else if (i < 8) drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else            drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      exp = (i == 8);
      n_checks++;
      if (det_a !== exp) begin
        n_fail++;
        $display("FAIL stall cycle%0d: det got %b required %b", i, det_a, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    test_reset();
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (det_a !== 1'b0 || armed_a !== 1'b0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream: det/armed/err %b%b%b required 000", det_a, armed_a, err_a);
    end
  endtask

  task automatic test_saturate();
    int highs;
    highs = 0;
    drive(1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      if (det_b === 1'b1) highs++;
      n_checks++;
      if (det_b !== (i >= 1)) begin
        n_fail++;
        $display("FAIL sat_det bit%0d: got %b required %b", i+1, det_b, (i >= 1));
      end
    end
    n_checks++;
    if (highs !== 7) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d required 7", highs);
    end
`ifdef SEQ_DET_COUNT_EN
    n_checks++;
    if (cnt_b !== 2'd3 || cnt_a !== 16'd7) begin
      n_fail++;
      $display("FAIL sat_count: got %0d/%0d required 3/7", cnt_b, cnt_a);
    end
`endif
  endtask

  task automatic test_random();
    bit ld;
    for (int c = 0; c < 600; c++) begin
      ld = ($urandom_range(0, 39) == 0);
      drive(ld, 8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      n_checks++;
      if (det_a !== m_det || det_b !== m_det || armed_a !== m_armed || err_a !== m_err) begin
        n_fail++;
        $display("FAIL random c%0d: det %b/%b armed %b err %b required det %b armed %b err %b",
                 c, det_a, det_b, armed_a, err_a, m_det, m_armed, m_err);
      end
`ifdef SEQ_DET_COUNT_EN
      n_checks++;
      if (cnt_a !== 16'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
        n_fail++;
        $display("FAIL random_count c%0d: got %0d/%0d required %0d/%0d",
                 c, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_stream_1011(1'b1);
    test_stream_1011(1'b0);
    test_illegal_cfg();
    test_stall();
    test_reset_midstream();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
